// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter
// Shares one single-port register memory between the AXI4-Lite write path
// (AW+W) and read path (AR). Only one transaction is in flight at a time.
// Each grant produces one memory access, then a B or R response that is held
// until the channel accepts it.
//
// By default, simultaneous requests are served round-robin.
// Define ARB_WR_PRIORITY_EN to make writes always win simultaneous requests.
//
// state   | meaning
// IDLE    | waiting for a request; grant is issued combinationally here
// WR_MEM  | one-cycle memory write (suppressed when out of range)
// WR_RESP | BRESP valid, waiting for wr_resp_ready
// RD_MEM  | one-cycle memory read enable (suppressed when out of range)
// RD_CAP  | capture mem_rdata / response code
// RD_RESP | RDATA/RRESP valid, waiting for rd_resp_ready
module axil_mem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  output logic                      wr_grant,
  output logic                      wr_resp_valid,
  output logic [1:0]                wr_resp,
  input  logic                      wr_resp_ready,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_grant,
  output logic                      rd_resp_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [1:0]                rd_resp,
  input  logic                      rd_resp_ready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_wr;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    in_range;
  logic                    take_wr;
  logic                    take_rd;

  // Compare at 32 bits so a full-size memory (MEM_DEPTH = 2^ADDR_WIDTH) never decode-errors.
  assign in_range = (32'(addr_q) < 32'(MEM_DEPTH));

  // Arbitration: decide which side (if any) is accepted this IDLE cycle.
  always_comb begin
    take_wr = 1'b0;
    take_rd = 1'b0;
    if ((state == IDLE) && !reset) begin
      if (wr_req && rd_req) begin
`ifdef ARB_WR_PRIORITY_EN
        take_wr = 1'b1;
`else
        take_wr = !last_wr;
        take_rd = last_wr;
`endif
      end else begin
        take_wr = wr_req;
        take_rd = rd_req;
      end
    end
  end

  // Next-state and output decode; memory signals stay zero unless an in-range access is active.
  always_comb begin
    state_nxt     = state;
    wr_grant      = take_wr;
    rd_grant      = take_rd;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    wr_resp_valid = 1'b0;
    wr_resp       = RESP_OKAY;
    rd_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (take_wr)      state_nxt = WR_MEM;
        else if (take_rd) state_nxt = RD_MEM;
      end
      WR_MEM: begin
        if (in_range) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_wstrb = wstrb_q;
        end
        state_nxt = WR_RESP;
      end
      WR_RESP: begin
        wr_resp_valid = 1'b1;
        wr_resp       = in_range ? RESP_OKAY : RESP_DECERR;
        if (wr_resp_ready) state_nxt = IDLE;
      end
      RD_MEM: begin
        if (in_range) begin
          mem_en   = 1'b1;
          mem_addr = addr_q;
        end
        state_nxt = RD_CAP;
      end
      RD_CAP: state_nxt = RD_RESP;
      RD_RESP: begin
        rd_resp_valid = 1'b1;
        if (rd_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus record of which side was served last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WR_MEM)      last_wr <= 1'b1;
      else if (state == RD_MEM) last_wr <= 1'b0;
    end
  end

  // Latch the accepted request, and capture read data/response in RD_CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_data <= '0;
      rd_resp <= RESP_OKAY;
    end else begin
      if (take_wr) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
        wstrb_q <= wr_strb;
      end else if (take_rd) begin
        addr_q <= rd_addr;
      end
      if (state == RD_CAP) begin
        rd_data <= in_range ? mem_rdata : '0;
        rd_resp <= in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb_axil_mem_arbiter
// Self-checking bench for axil_mem_arbiter with MEM_DEPTH=16 and ADDR_WIDTH=5.
// With this configuration, addresses 16..31 decode-error.
module tb_axil_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int DEPTH = 16;

`ifdef ARB_WR_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_grant, rd_grant;
  logic          wr_resp_valid, rd_resp_valid;
  logic [1:0]    wr_resp, rd_resp;
  logic          wr_resp_ready, rd_resp_ready;
  logic [DW-1:0] rd_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_clear;

  always #5 clk = ~clk;

  axil_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_grant(wr_grant), .wr_resp_valid(wr_resp_valid), .wr_resp(wr_resp),
    .wr_resp_ready(wr_resp_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_resp_ready(rd_resp_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Bench memory: byte-enabled writes and registered reads (data is valid the next cycle).
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= '0;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < SW; b++)
        if (mem_wstrb[b]) tb_mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr[3:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic wait_grant(input bit is_wr, input string name);
    int n = 0;
    @(negedge clk);
    while (!(is_wr ? wr_grant : rd_grant) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, is_wr ? wr_grant : rd_grant, 1);
  endtask

  task automatic do_reset();
    wr_req = 0; rd_req = 0; reset = 1; mem_clear = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0; mem_clear = 0;
  endtask

  // One transaction from a table row, with latency and memory-port checks.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    bit    ok;
    tag = $sformatf("v%0d", idx);
    ok  = (v.exp_resp == 2'b00);
    wr_resp_ready = 1; rd_resp_ready = 1;
    if (v.is_wr) begin
      wr_addr = v.addr; wr_data = v.data; wr_strb = v.strb; wr_req = 1;
      wait_grant(1, {tag, "_wgrant"});
      @(posedge clk); #1 wr_req = 0;
      @(negedge clk);
      chk({tag, "_mem_en"}, mem_en, ok);
      chk({tag, "_mem_we"}, mem_we, ok);
      chk({tag, "_mem_wstrb"}, mem_wstrb, ok ? v.strb : 4'h0);
      if (ok) begin
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_mem_wdata"}, mem_wdata, v.data);
      end
      @(negedge clk);
      chk({tag, "_bvalid"}, wr_resp_valid, 1);
      chk({tag, "_bresp"}, wr_resp, v.exp_resp);
      @(negedge clk);
      chk({tag, "_bvalid_drop"}, wr_resp_valid, 0);
    end else begin
      rd_addr = v.addr; rd_req = 1;
      wait_grant(0, {tag, "_rgrant"});
      @(posedge clk); #1 rd_req = 0;
      @(negedge clk);
      chk({tag, "_mem_en"}, mem_en, ok);
      chk({tag, "_mem_we"}, mem_we, 0);
      if (ok) chk({tag, "_mem_addr"}, mem_addr, v.addr);
      @(negedge clk);
      chk({tag, "_rvalid_early"}, rd_resp_valid, 0);
      @(negedge clk);
      chk({tag, "_rvalid"}, rd_resp_valid, 1);
      chk({tag, "_rdata"}, rd_data, v.exp_rdata);
      chk({tag, "_rresp"}, rd_resp, v.exp_resp);
      @(negedge clk);
      chk({tag, "_rvalid_drop"}, rd_resp_valid, 0);
    end
    @(posedge clk); #1;
  endtask

  byte           seq[$];
  string         exp_seq;
  logic [31:0]   model_mem [DEPTH];
  bit            wp, rp, busy, cur_wr, last_srv_wr, exp_w, exp_r;
  logic [31:0]   exp_data;
  logic [1:0]    exp_code;
  int            age;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
    wr_resp_ready = 0; rd_resp_ready = 0; reset = 1; mem_clear = 1;

    // Reset: grants stay low even while both requests are high.
    wr_req = 1; rd_req = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wgrant", wr_grant, 0);
    chk("rst_rgrant", rd_grant, 0);
    chk("rst_bvalid", wr_resp_valid, 0);
    chk("rst_rvalid", rd_resp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rresp", rd_resp, 0);
    chk("rst_bresp", wr_resp, 0);
    wr_req = 0; rd_req = 0;
    @(posedge clk); #1 reset = 0; mem_clear = 0;

    // Table of single transactions: basic, DECERR, partial strobe.
    vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 5'd3,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd20, 32'h12345678, 4'hF, 2'b11, 32'h0};
    vecs[3]  = '{1'b0, 5'd20, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h11223344, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'hAABBCCDD, 4'h3, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 5'd7,  32'h0,        4'h0, 2'b00, 32'h1122CCDD};
    vecs[7]  = '{1'b1, 5'd15, 32'hCAFEF00D, 4'hC, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 5'd15, 32'h0,        4'h0, 2'b00, 32'hCAFE0000};
    vecs[9]  = '{1'b0, 5'd16, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Contention after reset with both requests held high.
    do_reset();
    wr_addr = 5'd1; wr_data = 32'h01010101; wr_strb = 4'hF; rd_addr = 5'd2;
    wr_resp_ready = 1; rd_resp_ready = 1; wr_req = 1; rd_req = 1;
    for (int n = 0; n < 60 && seq.size() < 4; n++) begin
      @(negedge clk);
      chk("arb_both", wr_grant & rd_grant, 0);
      if (wr_grant) seq.push_back("W");
      else if (rd_grant) seq.push_back("R");
    end
    @(posedge clk); #1 wr_req = 0; rd_req = 0;
    repeat (6) @(posedge clk);
    #1;
    exp_seq = PRIO ? "WWWW" : "WRWR";
    chk("arb_count", seq.size(), 4);
    for (int i = 0; i < seq.size() && i < 4; i++)
      chk($sformatf("arb_order%0d", i), seq[i], exp_seq[i]);

    // Read response backpressure, with a new read held pending.
    run_vec('{1'b1, 5'd5, 32'h5A5A0005, 4'hF, 2'b00, 32'h0}, 90);
    rd_resp_ready = 0; rd_addr = 5'd5; rd_req = 1;
    wait_grant(0, "bp_grant");
    @(posedge clk); #1;
    for (int n = 0; n < 10 && !rd_resp_valid; n++) @(negedge clk);
    chk("bp_valid", rd_resp_valid, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", rd_resp_valid, 1);
      chk("bp_hold_data", rd_data, 32'h5A5A0005);
      chk("bp_hold_resp", rd_resp, 2'b00);
      chk("bp_no_grant", rd_grant | wr_grant, 0);
    end
    @(posedge clk); #1 rd_resp_ready = 1;
    @(negedge clk);
    chk("bp_last_valid", rd_resp_valid, 1);
    chk("bp_last_nogrant", rd_grant, 0);
    @(negedge clk);
    chk("bp_release_grant", rd_grant, 1);
    @(posedge clk); #1 rd_req = 0;
    repeat (5) @(posedge clk);
    #1;

    // Reset during RD_CAP aborts the read.
    rd_addr = 5'd3; rd_req = 1; rd_resp_ready = 1;
    wait_grant(0, "ra_grant");
    @(posedge clk); #1 rd_req = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("ra_rvalid", rd_resp_valid, 0);
    chk("ra_rdata", rd_data, 0);
    chk("ra_rresp", rd_resp, 0);
    chk("ra_mem_en", mem_en, 0);
    chk("ra_bvalid", wr_resp_valid, 0);
    chk("ra_grants", wr_grant | rd_grant, 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("ra_no_pulse", rd_resp_valid, 0);
    end
    @(posedge clk); #1;

    // Random traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    wp = 0; rp = 0; busy = 0; last_srv_wr = 0; age = 0; cur_wr = 0;
    exp_data = '0; exp_code = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1; wr_req = 1; wr_addr = 5'($urandom_range(0, 31));
        wr_data = $urandom; wr_strb = 4'($urandom_range(0, 15));
      end
      if (!rp && $urandom_range(0, 2) == 0) begin
        rp = 1; rd_req = 1; rd_addr = 5'($urandom_range(0, 31));
      end
      wr_resp_ready = 1'($urandom_range(0, 1));
      rd_resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_w = 0; exp_r = 0;
      if (!busy) begin
        if (wp && rp) begin
          exp_w = PRIO ? 1'b1 : !last_srv_wr;
          exp_r = !exp_w;
        end else begin
          exp_w = wp; exp_r = rp;
        end
      end
      chk("rnd_wgrant", wr_grant, exp_w);
      chk("rnd_rgrant", rd_grant, exp_r);
      if (exp_w || exp_r) begin
        busy = 1; age = 0; cur_wr = exp_w; last_srv_wr = exp_w;
        if (exp_w) begin
          wp = 0;
          if (wr_addr < DEPTH) begin
            for (int b = 0; b < SW; b++)
              if (wr_strb[b]) model_mem[wr_addr[3:0]][8*b +: 8] = wr_data[8*b +: 8];
            exp_code = 2'b00;
          end else exp_code = 2'b11;
        end else begin
          rp = 0;
          if (rd_addr < DEPTH) begin
            exp_data = model_mem[rd_addr[3:0]]; exp_code = 2'b00;
          end else begin
            exp_data = '0; exp_code = 2'b11;
          end
        end
      end else if (busy) begin
        age++;
        if (cur_wr) begin
          chk("rnd_bvalid", wr_resp_valid, age >= 2);
          chk("rnd_rvalid_idle", rd_resp_valid, 0);
          if (age >= 2) begin
            chk("rnd_bresp", wr_resp, exp_code);
            if (wr_resp_ready) busy = 0;
          end
        end else begin
          chk("rnd_rvalid", rd_resp_valid, age >= 3);
          chk("rnd_bvalid_idle", wr_resp_valid, 0);
          if (age >= 3) begin
            chk("rnd_rdata", rd_data, exp_data);
            chk("rnd_rresp", rd_resp, exp_code);
            if (rd_resp_ready) busy = 0;
          end
        end
      end else begin
        chk("rnd_idle_valids", wr_resp_valid | rd_resp_valid, 0);
      end
      @(posedge clk); #1;
      if (!wp) wr_req = 0;
      if (!rp) rd_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
